// File: rtl/matvec_if.sv
// Memory-read bus and result stream of the matrix-vector engine.
//   address/read/waitrequest  : row read request, held while waitrequest=1
//   readdata/readdatavalid    : one returned row, element 0 in the MSBs
//   c_valid/c_ready/c_data/c_index : one result C[r] per handshake
// master = engine side, slave = memory/consumer side.
interface matvec_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 32,
    parameter int unsigned CW = 2 * DW + $clog2(N)
);
    logic [AW-1:0]        address;
    logic                 read;
    logic [N*DW-1:0]      readdata;
    logic                 readdatavalid;
    logic                 waitrequest;
    logic                 c_valid;
    logic                 c_ready;
    logic [CW-1:0]        c_data;
    logic [$clog2(N)-1:0] c_index;

    modport master (
        output address, read, c_valid, c_data, c_index,
        input  readdata, readdatavalid, waitrequest, c_ready
    );

    modport slave (
        input  address, read, c_valid, c_data, c_index,
        output readdata, readdatavalid, waitrequest, c_ready
    );
endinterface

// File: rtl/matvec_engine.sv
// Matrix-vector engine: C[r] = sum_j A[r][j] * B[j], r = 0..N-1.
// Row base_addr holds B, row base_addr+1+r holds A row r. Rows are fetched one
// at a time (single outstanding read), each A row is multiplied over N cycles,
// and each result is offered on a valid/ready stream before the next fetch.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   start/base_addr : begin a job at the given row address (accepted in idle only)
//   busy, done      : job in progress / one-cycle completion pulse
//   bus             : memory read bus + result stream (matvec_if.master)
module matvec_engine #(
    parameter int unsigned N      = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned AW     = 32,
    parameter int unsigned CW     = 2 * DW + $clog2(N),
    parameter bit          SIGNED = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    output logic          busy,
    output logic          done,
    matvec_if.master      bus
);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned RW = $clog2(N + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAITD = 3'd2;
    localparam logic [2:0] MAC   = 3'd3;
    localparam logic [2:0] OUT   = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [RW-1:0]   row_q, row_d;     // memory row: 0 = B, 1..N = A rows
    logic [IW-1:0]   j_q, j_d;
    logic [N*DW-1:0] a_q, a_d;
    logic [N*DW-1:0] b_q, b_d;
    logic [CW-1:0]   acc_q, acc_d;

    logic [DW-1:0]   a_el, b_el;
    logic [2*DW-1:0] a_ext, b_ext, prod;
    logic [CW-1:0]   prod_ext;

    // Operands are extended to 2*DW first so a plain unsigned multiply yields
    // the correct low 2*DW bits for both signed and unsigned elements.
    always_comb begin
        a_el     = DW'(a_q >> (DW * (N - 1 - int'(j_q))));
        b_el     = DW'(b_q >> (DW * (N - 1 - int'(j_q))));
        a_ext    = {{DW{SIGNED & a_el[DW-1]}}, a_el};
        b_ext    = {{DW{SIGNED & b_el[DW-1]}}, b_el};
        prod     = a_ext * b_ext;
        prod_ext = {{(CW - 2 * DW){SIGNED & prod[2*DW-1]}}, prod};
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        row_d   = row_q;
        j_d     = j_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    row_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!bus.waitrequest) state_d = WAITD;
            end
            WAITD: begin
                if (bus.readdatavalid) begin
                    if (row_q == '0) begin
                        b_d     = bus.readdata;
                        row_d   = RW'(1);
                        state_d = REQ;
                    end else begin
                        a_d     = bus.readdata;
                        j_d     = '0;
                        acc_d   = '0;
                        state_d = MAC;
                    end
                end
            end
            MAC: begin
                acc_d = acc_q + prod_ext;
                j_d   = j_q + IW'(1);
                if (j_q == IW'(N - 1)) state_d = OUT;
            end
            OUT: begin
                if (bus.c_ready) begin
                    if (row_q == RW'(N)) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + RW'(1);
                        state_d = REQ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            row_q   <= '0;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            row_q   <= row_d;
            j_q     <= j_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        bus.read    = (state_q == REQ);
        bus.address = base_q + AW'(row_q);
        bus.c_valid = (state_q == OUT);
        bus.c_data  = (state_q == OUT) ? acc_q : '0;
        bus.c_index = (state_q == OUT) ? IW'(row_q - RW'(1)) : '0;
    end
endmodule

// File: doc/matvec_engine.md
MATVEC_ENGINE -- requirements
Module: matvec_engine

Interface
REQ-001 Parameters SHALL be:
- N, default 8, matrix dimension and row length in elements (2..16).
- DW, default 8, element width.
- AW, default 32, memory address width.
- CW, default 2*DW+$clog2(N), accumulator/result width.
- SIGNED, default 0, 0 = unsigned elements, 1 = two's-complement elements.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin one matrix-vector job.
- base_addr  in  AW  row address of vector B.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- address  out  AW  memory row address.
- read  out  1  memory read request.
- readdata  in  N*DW  one memory row.
- readdatavalid  in  1  readdata valid.
- waitrequest  in  1  memory busy, request not accepted.
- c_valid  out  1  result valid.
- c_ready  in  1  result accepted.
- c_data  out  CW  result C[r].
- c_index  out  $clog2(N)  row index r of c_data.

Function
REQ-003 The block SHALL compute C[r] = sum over j=0..N-1 of A[r][j]*B[j] for r=0..N-1.
REQ-004 Row mapping: B SHALL be the row at base_addr; A row r SHALL be the row at base_addr+1+r.
REQ-005 Element j of a row SHALL be readdata[N*DW-1-j*DW -: DW], so element 0 is in the MSBs.
REQ-006 States SHALL be IDLE, REQ, WAITD, MAC, OUT, DONE.
REQ-007 IDLE: start=1 SHALL latch base_addr and go to REQ for row 0; start SHALL be ignored in all other states.
REQ-008 REQ: read SHALL be 1 and address stable; the state SHALL be held while waitrequest=1; on the first cycle with waitrequest=0 the SHALL be to WAITD, with read=0.
REQ-009 WAITD: the first cycle with readdatavalid=1 SHALL capture readdata.
- Row 0 -> B buffer, then REQ for row 1.
- Any other row -> A buffer, then MAC.
REQ-010 readdatavalid outside WAITD SHALL be ignored; at most one read SHALL be outstanding.
REQ-011 MAC: exactly N cycles, one product per cycle, j=0..N-1. The accumulator SHALL be cleared on entry and SHALL be ready in OUT on the cycle after the last product.
REQ-012 Arithmetic:
- Products SHALL be 2*DW wide, sign- or zero-extended to CW per SIGNED.
- Accumulation SHALL be modulo 2^CW, wrapping with no saturation or flag.
REQ-013 OUT: c_valid=1 with c_data and c_index held stable until c_ready=1.
- On acceptance: r<N-1 -> REQ for the next row; r=N-1 -> DONE.
- No memory read SHALL issue while c_valid=1 and c_ready=0.
REQ-014 c_valid and c_ready both high on the first OUT cycle SHALL complete the transfer in that cycle.
REQ-015 DONE: done=1 for exactly one cycle, then IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 Per-row latency SHALL be 1 + waitrequest cycles + memory latency + N + 1 cycles, plus c_ready stall.

Reset
REQ-018 With rst_n=0 at a clock edge, the following SHALL hold from the next cycle:
- state = IDLE.
- busy, done, read, c_valid = 0.
- address, c_data, c_index = 0.
- Accumulator and buffers = 0.
REQ-019 Reset mid-job (any state) SHALL abandon the job with no further read or c_valid; a subsequent start SHALL run a complete, correct job.
REQ-020 Data returning after reset for a read issued before reset SHALL be ignored, per REQ-010.

Verification
REQ-021 N=8, unsigned, B=1..8, A=identity, zero-wait memory -> C = 1,2,...,8 on c_index 0..7, then one done pulse.
REQ-022 N=8, unsigned, all elements 0xFF -> every C = 520200 (0x7F008), no wrap at CW=19.
REQ-023 SIGNED=1, all elements 0x80 (-128) -> every C = 131072; SIGNED=1 with A=0xFF (-1), B=0x02 -> every C = -16.
REQ-024 waitrequest held 5 cycles in REQ -> read=1 and address stable all 5 cycles; c_ready=0 for 10 cycles in OUT -> c_data and c_index stable, no read issued.
REQ-025 rst_n=0 during MAC of row 3 -> all outputs 0 next cycle. A late readdatavalid is ignored. A new start then gives C equal to the REQ-021 values.
REQ-026 start pulsed while busy, and readdatavalid pulsed in IDLE -> no effect on results or state.
